// File: rtl/dn_rmw_writer.sv
// Write-port front end for the D0-D7 register RAM: byte/word writes are merged
// via read-modify-write, long writes go straight through. Owns the RAM port while busy.
module dn_rmw_writer #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [2:0]            req_size,
  output logic                  done,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            size_q;

  // Sequencer, request latch and the registered done pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      address_q <= '0;
      data_q    <= '0;
      size_q    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            address_q <= req_address;
            data_q    <= req_data;
            size_q    <= req_size;
            if (req_size[0] || req_size[1]) begin
              state <= READ;
            end else if (req_size[2]) begin
              state <= WRITE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          state <= WRITE;
        end
        WRITE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port ownership: CPU read address in IDLE, latched target otherwise
  always_comb begin
    req_ready   = (state == IDLE);
    busy        = (state != IDLE);
    mem_we      = (state == WRITE);
    mem_address = (state == IDLE) ? rd_address : address_q;
  end

  // Merge: size bit0 wins over bit1 wins over bit2; upper target bits come from the RMW read
  always_comb begin
    mem_data_in = '0;
    if (size_q[0]) begin
      mem_data_in = {mem_data_out[DATA_WIDTH-1:8], data_q[7:0]};
    end else if (size_q[1]) begin
      mem_data_in = {mem_data_out[DATA_WIDTH-1:16], data_q[15:0]};
    end else if (size_q[2]) begin
      mem_data_in = data_q;
    end
  end

  assign rd_data = mem_data_out;

endmodule

// File: tb/tb_dn_rmw_writer.sv
// Directed bench for dn_rmw_writer with a behavioural 8x32 synchronous-read RAM.
module tb_dn_rmw_writer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_address;
  logic [31:0] req_data;
  logic [2:0]  req_size;
  logic        done;
  logic        busy;
  logic [2:0]  rd_address;
  logic [31:0] rd_data;
  logic [2:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;

  // Backdoor preload port into the RAM model
  logic        bd_we;
  logic [2:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] ram [8];

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  dn_rmw_writer #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_address  (req_address),
    .req_data     (req_data),
    .req_size     (req_size),
    .done         (done),
    .busy         (busy),
    .rd_address   (rd_address),
    .rd_data      (rd_data),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Registered-read RAM, old data on read-during-write
  always @(posedge clock) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_address] <= mem_data_in;
    mem_data_out <= ram[mem_address];
  end

  always @(negedge clock) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [31:0] v);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = v;
    tick();
    bd_we = 1'b0;
  endtask

  // Issue one request and wait (bounded) for its done pulse
  task automatic run_req(input string tag, input logic [2:0] a, input logic [31:0] d, input logic [2:0] s);
    int n;
    req_valid = 1'b1;
    req_address = a;
    req_data = d;
    req_size = s;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 6) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    tick();
  endtask

  int w0;
  int d0;
  logic [31:0] snap [8];
  logic same;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_address = '0;
    req_data = '0;
    req_size = '0;
    rd_address = 3'd6;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr_pass", 32'(mem_address), 32'd6);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Long write to D3
    preload(3'd3, 32'h0000_0000);
    w0 = we_cnt;
    d0 = done_cnt;
    req_valid = 1'b1; req_address = 3'd3; req_data = 32'hDEAD_BEEF; req_size = 3'b100;
    check("long_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("long_we", 32'(mem_we), 32'd1);
    check("long_busy", 32'(busy), 32'd1);
    check("long_ready_busy", 32'(req_ready), 32'd0);
    check("long_maddr", 32'(mem_address), 32'd3);
    check("long_din", mem_data_in, 32'hDEAD_BEEF);
    check("long_done_early", 32'(done), 32'd0);
    tick();
    check("long_we_off", 32'(mem_we), 32'd0);
    check("long_done", 32'(done), 32'd1);
    check("long_ready_back", 32'(req_ready), 32'd1);
    check("long_ram", ram[3], 32'hDEAD_BEEF);
    tick();
    check("long_done_off", 32'(done), 32'd0);
    check("long_we_count", 32'(we_cnt - w0), 32'd1);
    check("long_done_count", 32'(done_cnt - d0), 32'd1);
    rd_address = 3'd3;
    tick();
    check("long_readback", rd_data, 32'hDEAD_BEEF);

    // Byte merge into D5
    preload(3'd5, 32'h1122_3344);
    req_valid = 1'b1; req_address = 3'd5; req_data = 32'hFFFF_FFAB; req_size = 3'b001;
    tick();
    req_valid = 1'b0;
    check("byte_read_busy", 32'(busy), 32'd1);
    check("byte_read_we", 32'(mem_we), 32'd0);
    check("byte_read_maddr", 32'(mem_address), 32'd5);
    tick();
    check("byte_write_busy", 32'(busy), 32'd1);
    check("byte_write_we", 32'(mem_we), 32'd1);
    check("byte_din", mem_data_in, 32'h1122_33AB);
    tick();
    check("byte_idle", 32'(busy), 32'd0);
    check("byte_done", 32'(done), 32'd1);
    check("byte_ram", ram[5], 32'h1122_33AB);
    tick();

    // Size priority then word merge on D0
    preload(3'd0, 32'hAABB_CCDD);
    run_req("prio", 3'd0, 32'h1234_5678, 3'b011);
    check("prio_ram", ram[0], 32'hAABB_CC78);
    run_req("word", 3'd0, 32'h1234_5678, 3'b010);
    check("word_ram", ram[0], 32'hAABB_5678);
    run_req("word_upper_ignored", 3'd0, 32'hFFFF_0001, 3'b110);
    check("word2_ram", ram[0], 32'hAABB_0001);

    // Back-to-back with held valid: byte D1 then long D2
    preload(3'd1, 32'hCAFE_F00D);
    preload(3'd2, 32'hFFFF_FFFF);
    rd_address = 3'd2;
    d0 = done_cnt;
    req_valid = 1'b1; req_address = 3'd1; req_data = 32'hFFFF_FF55; req_size = 3'b001;
    tick();
    req_address = 3'd2; req_data = 32'h0123_4567; req_size = 3'b100;
    check("b2b_ready_lo1", 32'(req_ready), 32'd0);
    tick();
    check("b2b_ready_lo2", 32'(req_ready), 32'd0);
    tick();
    check("b2b_ready_hi", 32'(req_ready), 32'd1);
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_ram1", ram[1], 32'hCAFE_F055);
    tick();
    req_valid = 1'b0;
    check("b2b_we2", 32'(mem_we), 32'd1);
    check("b2b_maddr2", 32'(mem_address), 32'd2);
    check("b2b_done_gap", 32'(done), 32'd0);
    tick();
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_ram2", ram[2], 32'h0123_4567);
    tick();
    check("raw_readback", rd_data, 32'h0123_4567);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Reset during READ of a byte write to D7
    preload(3'd7, 32'h0102_0304);
    w0 = we_cnt;
    d0 = done_cnt;
    req_valid = 1'b1; req_address = 3'd7; req_data = 32'h0000_00EE; req_size = 3'b001;
    tick();
    req_valid = 1'b0;
    check("rmid_in_read", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rmid_we_async", 32'(mem_we), 32'd0);
    check("rmid_busy_async", 32'(busy), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    check("rmid_ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    check("rmid_we_count", 32'(we_cnt - w0), 32'd0);
    check("rmid_done_count", 32'(done_cnt - d0), 32'd0);
    check("rmid_ram", ram[7], 32'h0102_0304);

    // Null size: done pulse only
    for (int i = 0; i < 8; i++) snap[i] = ram[i];
    w0 = we_cnt;
    d0 = done_cnt;
    req_valid = 1'b1; req_address = 3'd4; req_data = 32'h5A5A_5A5A; req_size = 3'b000;
    tick();
    req_valid = 1'b0;
    check("null_done", 32'(done), 32'd1);
    check("null_busy", 32'(busy), 32'd0);
    check("null_ready", 32'(req_ready), 32'd1);
    tick();
    check("null_done_off", 32'(done), 32'd0);
    tick();
    check("null_we_count", 32'(we_cnt - w0), 32'd0);
    check("null_done_count", 32'(done_cnt - d0), 32'd1);
    same = 1'b1;
    for (int i = 0; i < 8; i++) if (ram[i] !== snap[i]) same = 1'b0;
    check("null_ram_same", 32'(same), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dn_rmw_writer.md
Name: dn_rmw_writer

Overview:
- Write-port front end for the D0-D7 register RAM (8 x 32, synchronous read with 1-cycle latency, no byte enables).
- Takes sized write requests from the execution datapath and performs the byte and word merges in RTL. Byte and word writes use a read-modify-write; long writes are direct.
- Owns the RAM port while a write is in progress. While idle it passes the CPU read address through.

Parameters:
- ADDR_WIDTH, 3, register index width (8 data registers)
- DATA_WIDTH, 32, register width; merge logic is defined for 32 only

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  write request present
- req_ready  out  1  block can accept a request this cycle
- req_address  in  ADDR_WIDTH  target Dn index
- req_data  in  32  write data, right-aligned
- req_size  in  3  001 byte, 010 word, 100 long; priority bit0 > bit1 > bit2
- done  out  1  one-cycle pulse after the RAM write edge
- busy  out  1  state != IDLE
- rd_address  in  ADDR_WIDTH  CPU read index, honoured only in IDLE
- rd_data  out  32  equals mem_data_out; valid 1 cycle after rd_address is sampled in IDLE
- mem_address  out  ADDR_WIDTH  to Dn RAM address
- mem_data_in  out  32  to Dn RAM write data
- mem_we  out  1  to Dn RAM write enable
- mem_data_out  in  32  from Dn RAM registered read data

Behaviour:
- Reset: state=IDLE; latched address, data and size cleared; done=0; busy=0.
- Reset outputs: mem_we=0; req_ready=1; mem_address=rd_address.
- State machine: IDLE, READ, WRITE. All outputs except done are combinational from state and latched registers. done is registered.
- IDLE:
  - req_ready=1, mem_we=0, mem_address=rd_address.
  - On req_valid, latch address, data and size.
  - Next state: size bit0 or bit1 -> READ; only bit2 -> WRITE; size 000 -> stay IDLE, pulse done next cycle, no RAM write.
- READ:
  - req_ready=0, mem_address=latched address, mem_we=0.
  - Unconditionally -> WRITE.
- WRITE:
  - req_ready=0, mem_address=latched address, mem_we=1.
  - mem_data_in: byte = {mem_data_out[31:8], data[7:0]}; word = {mem_data_out[31:16], data[15:0]}; long = data.
  - mem_data_out is the registered read from READ; it is ignored for long writes.
  - Next state IDLE; done=1 in the following cycle.
- Latency, from accept edge E0:
  - Long: written at E1, done high during the cycle after E1, ready again after E1 (2 cycles per write).
  - Byte/word: written at E2, done high the cycle after E2 (3 cycles per write).
- Back-to-back: a new request is accepted only in IDLE. No overlap and no request queue. Upstream holds req_* until it sees req_ready=1 with req_valid=1.
- req_data bits above the selected size are ignored. Upper bits of the target register are preserved exactly.
- CPU reads issued while busy are not serviced. rd_data during busy reflects the RMW read and must be treated as invalid.
- Read of the register just written: rd_address presented in the first IDLE cycle after WRITE returns the new value one cycle later.
- Reset mid-operation: immediate return to IDLE and mem_we deasserts asynchronously. The pending write is lost, no done pulse, and RAM contents are unchanged unless the write edge had already occurred.

Test Plan:
- Long write: D3=0x00000000; req addr 3, data 0xDEADBEEF, size 100 -> mem_we high exactly 1 cycle, done 1 cycle later; read D3 = 0xDEADBEEF.
- Byte merge: D5=0x11223344; req addr 5, data 0xFFFFFFAB, size 001 -> READ then WRITE; D5 = 0x112233AB; busy high 2 cycles.
- Word merge and priority: D0=0xAABBCCDD; data 0x12345678, size 011 -> treated as byte, D0=0xAABBCC78. Then size 010 -> D0=0xAABB5678.
- Back-to-back with held valid: byte to D1 immediately followed by long to D2 -> req_ready low 2 cycles, second request accepted on the first IDLE cycle; both registers correct; two done pulses.
- Reset mid-RMW: assert reset during READ of a byte write to D7=0x01020304 -> mem_we never asserted, no done, D7 unchanged, req_ready=1 after reset release.
- Null size: size 000 -> no mem_we, done pulses once, RAM unchanged.
